imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port 32x64k instruction memory between the instruction
//  fetch stage and an external loader/debug port (program load, readback).
//  Grants the one memory port per cycle and routes read data back to its owner.
//  Stalls fetch while the loader owns the port.
//  A fairness counter stops the loader from starving fetch indefinitely.
// PARAMETERS
//  AW       16  memory address width (words)
//  DW       32  memory data width
//  MAX_EXT   4  max consecutive loader grants before one forced fetch grant (>=1)
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  rst            in   1   synchronous reset, active-high
//  fetch_req_i    in   1   fetch wants a read this cycle
//  fetch_addr_i   in   AW  fetch read address
//  fetch_stall_o  out  1   fetch not granted this cycle; hold PC/address
//  fetch_inst_o   out  DW  read data for fetch (valid with fetch_valid_o)
//  fetch_valid_o  out  1   fetch_inst_o carries data for last-cycle fetch grant
//  ext_req_i      in   1   loader request; hold all ext_* inputs stable until granted
//  ext_we_i       in   1   1 = write, 0 = read
//  ext_addr_i     in   AW  loader address
//  ext_wdata_i    in   DW  loader write data
//  ext_gnt_o      out  1   loader request accepted this cycle
//  ext_rdata_o    out  DW  loader read data (valid with ext_rvalid_o)
//  ext_rvalid_o   out  1   read data for last-cycle loader read grant
//  mem_a_o        out  AW  memory address
//  mem_w_o        out  1   memory write enable
//  mem_d_o        out  DW  memory write data
//  mem_q_i        in   DW  memory read data, 1-cycle latency after mem_a_o
// BEHAVIOUR
//  - Reset (rst=1 at posedge): owner_r=NONE, ext_cnt=0, fetch_valid_o=0,
//    ext_rvalid_o=0. While rst=1, comb outputs are forced: ext_gnt_o=0,
//    mem_w_o=0, fetch_stall_o=fetch_req_i, mem_a_o=0, mem_d_o=0.
//  - Grant (comb, each cycle):
//      ext wins if ext_req_i && (ext_cnt < MAX_EXT || !fetch_req_i);
//      else fetch wins if fetch_req_i; else no grant.
//  - Ext grant: ext_gnt_o=1, mem_a_o=ext_addr_i, mem_w_o=ext_we_i,
//    mem_d_o=ext_wdata_i, fetch_stall_o=fetch_req_i.
//  - Fetch grant: mem_a_o=fetch_addr_i, mem_w_o=0, fetch_stall_o=0.
//  - No grant: mem_a_o holds last granted address, mem_w_o=0.
//  - Loader writes complete in the grant cycle (ack = ext_gnt_o); no rvalid.
//  - Registered owner_r in {NONE,FETCH,EXT_RD}, captured at posedge from the
//    grant. Next cycle: fetch_valid_o=(owner_r==FETCH),
//    ext_rvalid_o=(owner_r==EXT_RD). fetch_inst_o and ext_rdata_o both
//    = mem_q_i (no extra register).
//  - ext_cnt: +1 on each ext grant while fetch_req_i=1 (saturates at MAX_EXT);
//    cleared on fetch grant or when fetch_req_i=0.
//    Result: continuous contention gives MAX_EXT ext grants, 1 fetch, repeat.
//  - Read after write to the same address in back-to-back cycles is legal.
//    Data returned is whatever the memory returns; the arbiter adds no bypass.
//  - Reset mid-transaction: a pending read's valid is dropped. A loader
//    request must be re-presented and waits for a new grant.
//  - Latency: fetch read 1 cycle when uncontended. Loader worst-case wait
//    is 1 cycle; fetch worst-case wait is MAX_EXT cycles.
// TESTING
//  1 Fetch only, addr 0,1,2 on consecutive cycles -> mem_a_o=0,1,2; stall=0;
//    fetch_valid_o=1 one cycle later with mem contents of 0,1,2.
//  2 Fetch active + ext write 0x0010<=0xDEADBEEF -> that cycle: ext_gnt_o=1,
//    mem_w_o=1, mem_a_o=0x0010, mem_d_o=0xDEADBEEF, fetch_stall_o=1.
//    Next cycle: fetch granted again.
//  3 Ext read 0x0010 the cycle after test 2's write -> ext_gnt_o=1, mem_w_o=0;
//    next cycle ext_rvalid_o=1, ext_rdata_o=0xDEADBEEF, fetch_valid_o=0.
//  4 fetch_req_i=1 and ext_req_i=1 held for 10 cycles, MAX_EXT=4 ->
//    grant pattern E,E,E,E,F,E,E,E,E,F; fetch_stall_o=0 only on F cycles.
//  5 ext_req_i alone (fetch_req_i=0) for 8 cycles -> ext granted all 8 cycles;
//    ext_cnt stays 0.
//  6 rst=1 for 1 cycle in the middle of test 4 -> at next cycle
//    fetch_valid_o=0, ext_rvalid_o=0, ext_cnt=0. After release, pattern
//    restarts with 4 E grants before an F grant.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Arbitrates the single instruction-memory port between the fetch stage and
// the external loader/debug port. The loader has priority, but a saturating
// counter forces one fetch grant after MAX_EXT consecutive loader grants won
// against a waiting fetch. Read data returns one cycle after the grant and is
// tagged for its owner through a registered owner marker.
module imem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MAX_EXT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_stall_o,
    output logic [DW-1:0] fetch_inst_o,
    output logic          fetch_valid_o,

    input  logic          ext_req_i,
    input  logic          ext_we_i,
    input  logic [AW-1:0] ext_addr_i,
    input  logic [DW-1:0] ext_wdata_i,
    output logic          ext_gnt_o,
    output logic [DW-1:0] ext_rdata_o,
    output logic          ext_rvalid_o,

    output logic [AW-1:0] mem_a_o,
    output logic          mem_w_o,
    output logic [DW-1:0] mem_d_o,
    input  logic [DW-1:0] mem_q_i
);

    localparam int            CW      = $clog2(MAX_EXT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_EXT);

    // Who owns the data coming back from memory in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_EXT_RD
    } owner_e;

    owner_e        owner_q,     owner_d;
    logic [CW-1:0] ext_cnt_q,   ext_cnt_d;
    logic [AW-1:0] last_addr_q, last_addr_d;

    logic ext_win;
    logic fetch_win;

    // Grant decision: loader first unless it has used up its run against a waiting fetch.
    always_comb begin
        ext_win   = 1'b0;
        fetch_win = 1'b0;
        if (!rst) begin
            ext_win   = ext_req_i && ((ext_cnt_q < MAX_CNT) || !fetch_req_i);
            fetch_win = fetch_req_i && !ext_win;
        end
    end

    // Next-state and memory-port drive; reset forces the port quiet.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        owner_d       = OWN_NONE;
        ext_cnt_d     = ext_cnt_q;
        last_addr_d   = last_addr_q;
        ext_gnt_o     = ext_win;
        fetch_stall_o = fetch_req_i && !fetch_win;
        mem_a_o       = last_addr_q;
        mem_w_o       = 1'b0;
        mem_d_o       = ext_wdata_i;

        if (rst) begin
            mem_a_o = '0;
            mem_d_o = '0;
        end else if (ext_win) begin
            mem_a_o     = ext_addr_i;
            mem_w_o     = ext_we_i;
            last_addr_d = ext_addr_i;
            if (!ext_we_i) begin
                owner_d = OWN_EXT_RD;
            end
        end else if (fetch_win) begin
            mem_a_o     = fetch_addr_i;
            last_addr_d = fetch_addr_i;
            owner_d     = OWN_FETCH;
        end

        // The run length only matters while fetch is waiting; any fetch grant
        // or an idle fetch starts a fresh run.
        if (!fetch_req_i || fetch_win) begin
            ext_cnt_d = '0;
        end else if (ext_win && (ext_cnt_q != MAX_CNT)) begin
            ext_cnt_d = ext_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset; dropping the owner discards any pending read valid.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            owner_q     <= OWN_NONE;
            ext_cnt_q   <= '0;
            last_addr_q <= '0;
        end else begin
            owner_q     <= owner_d;
            ext_cnt_q   <= ext_cnt_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign fetch_valid_o = (owner_q == OWN_FETCH);
    assign ext_rvalid_o  = (owner_q == OWN_EXT_RD);
    assign fetch_inst_o  = mem_q_i;
    assign ext_rdata_o   = mem_q_i;

endmodule
